// File: rtl/dbg_pkg.sv
// Shared definitions for the debug display: active-low 7-segment hex glyphs
// ({dp,g,f,e,d,c,b,a}) and elaboration-time width helpers.
package dbg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index widths must never collapse to zero bits, even for a single entry.
  function automatic int bits_min1(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex nibble to active-low 7-segment glyph; dp is always dark
// here and is overlaid by the caller.
module seg7_hex
  import dbg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dbg_display.sv
// Debug display engine: picks a (channel, nibble window) of the debug words,
// snapshots it once per frame and scans it onto a multiplexed 7-seg display.
module dbg_display
  import dbg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CHANNELS = 8,
  parameter int CH_W     = 32,
  parameter int SCAN_DIV = 16,
  parameter int ROT_DIV  = 26,
  localparam int WINS    = CH_W / (4 * DIGITS),
  localparam int CW      = clog2(CHANNELS),
  localparam int WW      = bits_min1(WINS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*CH_W-1:0] ch_data,
  input  logic [CW-1:0]            ch_sel,
  input  logic [WW-1:0]            win_sel,
  input  logic                     auto_mode,
  input  logic                     freeze,
  output logic [7:0]               digit_led,
  output logic [DIGITS-1:0]        digit_sel,
  output logic [CW-1:0]            cur_ch,
  output logic [WW-1:0]            cur_win
);

  localparam int IW = bits_min1(DIGITS);
  localparam int SW = 4 * DIGITS;

  logic [SCAN_DIV-1:0] presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [ROT_DIV-1:0]  rot_q, rot_d;
  logic [CW-1:0]       cur_ch_q, cur_ch_d;
  logic [WW-1:0]       cur_win_q, cur_win_d;
  logic [SW-1:0]       snap_q, snap_d;
  logic                auto_q, auto_d;
  logic [7:0]          led_q, led_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic                scan_wrap;
  logic                frame_end;
  logic                last_digit;
  logic                auto_rise;
  logic                rot_wrap;
  logic [CW-1:0]       ch_clamp;
  logic [WW-1:0]       win_clamp;
  logic [SW-1:0]       win_word;
  logic [3:0]          nibble;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel_next;
  logic                dp_n;

  seg7_hex u_seg7_hex (
    .nibble (nibble),
    .seg    (seg)
  );

  assign scan_wrap  = &presc_q;
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign frame_end  = scan_wrap && last_digit;
  assign auto_rise  = auto_mode && !auto_q;
  assign rot_wrap   = &rot_q;

  always_comb begin
    ch_clamp  = ch_sel;
    win_clamp = win_sel;
    if (int'(ch_sel) > CHANNELS - 1) ch_clamp = CW'(CHANNELS - 1);
    if (int'(win_sel) > WINS - 1) win_clamp = WW'(WINS - 1);
  end

  always_comb begin
    win_word = ch_data[int'(cur_ch_q) * CH_W + int'(cur_win_q) * SW +: SW];
  end

  // The index names the digit lit at the next slot boundary, so the first
  // slot after reset shows digit 0 and the frame ends as digit DIGITS-1 lights.
  always_comb begin
    nibble      = snap_q[int'(idx_q) * 4 +: 4];
    dp_n        = !(auto_mode && last_digit);
    sel_next    = '1;
    sel_next[idx_q] = 1'b0;
  end

  always_comb begin
    presc_d = presc_q + SCAN_DIV'(1);
    idx_d   = idx_q;
    led_d   = led_q;
    sel_d   = sel_q;
    snap_d  = snap_q;
    auto_d  = auto_mode;
    if (scan_wrap) begin
      idx_d = last_digit ? '0 : idx_q + IW'(1);
      led_d = {seg[7] & dp_n, seg[6:0]};
      sel_d = sel_next;
    end
    if (frame_end && !freeze) snap_d = win_word;
  end

  always_comb begin
    cur_ch_d  = cur_ch_q;
    cur_win_d = cur_win_q;
    rot_d     = rot_q;
    if (!freeze) begin
      if (!auto_mode) begin
        cur_ch_d  = ch_clamp;
        cur_win_d = win_clamp;
      end else if (auto_rise) begin
        rot_d = '0;
      end else begin
        rot_d = rot_q + ROT_DIV'(1);
        if (rot_wrap) begin
          if (cur_win_q == WW'(WINS - 1)) begin
            cur_win_d = '0;
            cur_ch_d  = (cur_ch_q == CW'(CHANNELS - 1)) ? '0 : cur_ch_q + CW'(1);
          end else begin
            cur_win_d = cur_win_q + WW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      rot_q     <= '0;
      cur_ch_q  <= '0;
      cur_win_q <= '0;
      snap_q    <= '0;
      auto_q    <= 1'b0;
      led_q     <= SEG_BLANK;
      sel_q     <= '1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      rot_q     <= rot_d;
      cur_ch_q  <= cur_ch_d;
      cur_win_q <= cur_win_d;
      snap_q    <= snap_d;
      auto_q    <= auto_d;
      led_q     <= led_d;
      sel_q     <= sel_d;
    end
  end

  assign digit_led = led_q;
  assign digit_sel = sel_q;
  assign cur_ch    = cur_ch_q;
  assign cur_win   = cur_win_q;

endmodule

// File: tb/tb_dbg_display.sv
// Directed bench for dbg_display with fast scan/rotate dividers; a second
// six-channel instance covers channel-select clamping.
module tb_dbg_display;

  localparam int CH_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4*CH_W-1:0] ch_data;
  logic [1:0]        ch_sel;
  logic [0:0]        win_sel;
  logic              auto_mode;
  logic              freeze;
  logic [7:0]        digit_led;
  logic [3:0]        digit_sel;
  logic [1:0]        cur_ch;
  logic [0:0]        cur_win;

  logic [6*CH_W-1:0] ch_data6;
  logic [2:0]        ch_sel6;
  logic [0:0]        win_sel6;
  logic              auto6;
  logic              freeze6;
  logic [7:0]        digit_led6;
  logic [3:0]        digit_sel6;
  logic [2:0]        cur_ch6;
  logic [0:0]        cur_win6;

  dbg_display #(.DIGITS(4), .CHANNELS(4), .CH_W(32), .SCAN_DIV(2), .ROT_DIV(5)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_sel(ch_sel), .win_sel(win_sel),
    .auto_mode(auto_mode), .freeze(freeze), .digit_led(digit_led), .digit_sel(digit_sel),
    .cur_ch(cur_ch), .cur_win(cur_win)
  );

  dbg_display #(.DIGITS(4), .CHANNELS(6), .CH_W(32), .SCAN_DIV(2), .ROT_DIV(5)) dut6 (
    .clk(clk), .rst(rst), .ch_data(ch_data6), .ch_sel(ch_sel6), .win_sel(win_sel6),
    .auto_mode(auto6), .freeze(freeze6), .digit_led(digit_led6), .digit_sel(digit_sel6),
    .cur_ch(cur_ch6), .cur_win(cur_win6)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ch;
    logic        win;
    logic [31:0] exp;   // expected digit_led, byte i = digit i
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Waits (bounded) for a fresh slot in which digit_sel equals s.
  task automatic wait_sel(input logic [3:0] s, input string name);
    int k;
    k = 0;
    while (digit_sel == s && k < 64) begin @(negedge clk); k++; end
    while (digit_sel != s && k < 64) begin @(negedge clk); k++; end
    if (k >= 64) begin
      n_total++;
      $display("FAIL %s: timeout waiting for digit_sel %b, got %b", name, s, digit_sel);
    end
  endtask

  task automatic capture_frame(input logic [31:0] exp, input string tag);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] s;
      s = ~(4'b0001 << i);
      wait_sel(s, tag);
      check($sformatf("%s_dig%0d", tag, i), 32'(digit_led), 32'(exp[i*8 +: 8]));
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int k = 0; k < 4; k++) ch_data[k*32 +: 32] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  scan_exp [4];
    logic [31:0] exp_frz;
    int          bad_cur, bad_led;

    vecs[0] = '{32'h0040_1A2C, 2'd0, 1'b0, 32'hF988A4C6};
    vecs[1] = '{32'h0040_1A2C, 2'd0, 1'b1, 32'hC0C099C0};
    vecs[2] = '{32'h3579_BDEF, 2'd2, 1'b0, 32'h83A1868E};
    vecs[3] = '{32'h3579_BDEF, 2'd2, 1'b1, 32'hB092F890};
    vecs[4] = '{32'h8642_0000, 2'd3, 1'b1, 32'h808299A4};
    scan_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    ch_data = '0; ch_sel = '0; win_sel = '0; auto_mode = 1'b0; freeze = 1'b0;
    ch_data6 = '0; ch_sel6 = 3'd7; win_sel6 = '0; auto6 = 1'b0; freeze6 = 1'b0;

    // Reset and scan timing
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_led", 32'(digit_led), 32'hFF);
    check("reset_sel", 32'(digit_sel), 32'hF);
    check("reset_cur_ch", 32'(cur_ch), 32'h0);
    check("reset_cur_win", 32'(cur_win), 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dark_before_first_slot", 32'(digit_sel), 32'hF);
    @(posedge clk); @(negedge clk);
    check("first_slot_sel", 32'(digit_sel), 32'hE);
    check("first_slot_led", 32'(digit_led), 32'hC0);
    check("clamp6_ch7", 32'(cur_ch6), 32'd5);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("scan_slot%0d", i + 1), 32'(digit_sel), 32'(scan_exp[i]));
    end

    // Table-driven manual selection
    for (int v = 0; v < 5; v++) begin
      set_all(32'h0);
      ch_data[int'(vecs[v].ch)*32 +: 32] = vecs[v].data;
      ch_sel  = vecs[v].ch;
      win_sel = vecs[v].win;
      @(posedge clk); @(negedge clk);
      check($sformatf("vec%0d_cur_ch", v), 32'(cur_ch), 32'(vecs[v].ch));
      check($sformatf("vec%0d_cur_win", v), 32'(cur_win), 32'(vecs[v].win));
      wait_sel(4'b0111, $sformatf("vec%0d_boundary", v));
      capture_frame(vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Mid-frame data change must not tear the current frame
    set_all(32'h0);
    ch_data[31:0] = 32'h0040_1A2C;
    ch_sel = 2'd0; win_sel = 1'b0;
    @(posedge clk); @(negedge clk);
    wait_sel(4'b0111, "tear_boundary");
    capture_frame(32'hF988A4C6, "pre_tear");
    wait_sel(4'b1110, "tear_dig0");
    check("tear_dig0", 32'(digit_led), 32'hC6);
    ch_data[31:0] = 32'h0000_5555;
    wait_sel(4'b1101, "tear_dig1");
    check("tear_dig1_old", 32'(digit_led), 32'hA4);
    wait_sel(4'b1011, "tear_dig2");
    check("tear_dig2_old", 32'(digit_led), 32'h88);
    wait_sel(4'b0111, "tear_dig3");
    check("tear_dig3_old", 32'(digit_led), 32'hF9);
    wait_sel(4'b1110, "tear_new0");
    check("tear_dig0_new", 32'(digit_led), 32'h92);
    wait_sel(4'b1101, "tear_new1");
    check("tear_dig1_new", 32'(digit_led), 32'h92);

    // Auto-rotate from (3,1); identical windows keep the snapshot predictable
    set_all(32'h5A5A_5A5A);
    ch_sel = 2'd3; win_sel = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("manual_3_1_ch", 32'(cur_ch), 32'd3);
    check("manual_3_1_win", 32'(cur_win), 32'd1);
    auto_mode = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("auto_hold_ch", 32'(cur_ch), 32'd3);
    check("auto_hold_win", 32'(cur_win), 32'd1);
    @(posedge clk); @(negedge clk);
    check("auto_step1_ch", 32'(cur_ch), 32'd0);
    check("auto_step1_win", 32'(cur_win), 32'd0);
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("auto_step2_ch", 32'(cur_ch), 32'd0);
    check("auto_step2_win", 32'(cur_win), 32'd1);

    // Freeze while data toggles; dp only on digit 3
    freeze  = 1'b1;
    exp_frz = 32'h12889288;
    bad_cur = 0;
    bad_led = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      set_all(c[0] ? 32'hFFFF_FFFF : 32'h0000_0000);
      if (cur_ch != 2'd0 || cur_win != 1'b1) bad_cur++;
      for (int i = 0; i < 4; i++) begin
        if (digit_sel == ~(4'b0001 << i) && digit_led != exp_frz[i*8 +: 8]) bad_led++;
      end
    end
    check("freeze_cur_errors", 32'(bad_cur), 32'd0);
    check("freeze_led_errors", 32'(bad_led), 32'd0);

    // Release freeze for exactly the frame-boundary cycle
    set_all(32'hC3C3_C3C3);
    wait_sel(4'b1011, "release_slot2");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_release_sel", 32'(digit_sel), 32'hB);
    freeze = 1'b0;
    @(posedge clk); @(negedge clk);
    freeze = 1'b1;
    check("release_boundary_sel", 32'(digit_sel), 32'h7);
    capture_frame(32'h46B0C6B0, "release");

    // Leave auto, then re-enter with a non-zero rotate counter
    freeze = 1'b0; auto_mode = 1'b0;
    ch_sel = 2'd1; win_sel = 1'b0;
    @(posedge clk); @(negedge clk);
    check("leave_auto_ch", 32'(cur_ch), 32'd1);
    check("leave_auto_win", 32'(cur_win), 32'd0);
    auto_mode = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("reenter_hold_win", 32'(cur_win), 32'd0);
    @(posedge clk); @(negedge clk);
    check("reenter_step_ch", 32'(cur_ch), 32'd1);
    check("reenter_step_win", 32'(cur_win), 32'd1);
    auto_mode = 1'b0;

    // Clamping on the six-channel instance
    ch_sel6 = 3'd4;
    @(posedge clk); @(negedge clk);
    check("clamp6_ch4", 32'(cur_ch6), 32'd4);
    ch_sel6 = 3'd6; win_sel6 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("clamp6_ch6", 32'(cur_ch6), 32'd5);
    check("clamp6_win", 32'(cur_win6), 32'd1);

    // Reset mid-frame
    wait_sel(4'b1101, "midreset_slot");
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midreset_led", 32'(digit_led), 32'hFF);
    check("midreset_sel", 32'(digit_sel), 32'hF);
    check("midreset_cur_ch", 32'(cur_ch), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_dark_slot", 32'(digit_sel), 32'hF);
    @(posedge clk); @(negedge clk);
    check("midreset_first_sel", 32'(digit_sel), 32'hE);
    check("midreset_first_led", 32'(digit_led), 32'hC0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
